// File: rtl/square_accumulator.sv
// rtl/square_accumulator.sv - frame accumulator of squared samples emitting sum and mean per 2^LOG2_COUNT samples
// Optional running-peak output enabled by defining SQUARE_ACCUMULATOR_PEAK_EN.
module square_accumulator #(
  parameter int WIDTH      = 16,
  parameter int LOG2_COUNT = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [WIDTH-1:0]            sample_in,
  input  logic                        sample_valid_in,
  input  logic                        clear_in,
  output logic [WIDTH+LOG2_COUNT-1:0] sum_out,
  output logic [WIDTH-1:0]            mean_out,
  output logic                        valid_out,
`ifdef SQUARE_ACCUMULATOR_PEAK_EN
  output logic [WIDTH-1:0]            peak_out,
`endif
  output logic [LOG2_COUNT-1:0]       count_out
);

  localparam int SUM_W = WIDTH + LOG2_COUNT;
  localparam logic [LOG2_COUNT-1:0] LAST_IDX = {LOG2_COUNT{1'b1}};

  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] next_sum;
  logic             accept;
  logic             last_sample;

  assign accept      = sample_valid_in & ~clear_in;
  assign last_sample = (count_out == LAST_IDX);
  // Accumulator is wide enough for a full frame of all-ones samples.
  assign next_sum    = acc + {{LOG2_COUNT{1'b0}}, sample_in};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc       <= '0;
      count_out <= '0;
      sum_out   <= '0;
      mean_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (clear_in) begin
        acc       <= '0;
        count_out <= '0;
      end else if (accept) begin
        count_out <= count_out + 1'b1;
        if (last_sample) begin
          acc       <= '0;
          sum_out   <= next_sum;
          mean_out  <= next_sum[SUM_W-1:LOG2_COUNT];
          valid_out <= 1'b1;
        end else begin
          acc <= next_sum;
        end
      end
    end
  end

`ifdef SQUARE_ACCUMULATOR_PEAK_EN
  logic [WIDTH-1:0] run_peak;
  logic [WIDTH-1:0] next_peak;

  assign next_peak = (sample_in > run_peak) ? sample_in : run_peak;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      run_peak <= '0;
      peak_out <= '0;
    end else if (clear_in) begin
      run_peak <= '0;
    end else if (accept) begin
      if (last_sample) begin
        run_peak <= '0;
        peak_out <= next_peak;
      end else begin
        run_peak <= next_peak;
      end
    end
  end
`endif

endmodule

// File: doc/square_accumulator.md
Name: square_accumulator

Overview:
- Sits directly downstream of the squaring stage and consumes its `square_out`/`valid_out` result stream.
- Accumulates a frame of 2^LOG2_COUNT squared samples.
- Per frame, emits the exact sum and the mean (sum right-shifted by LOG2_COUNT) with a one-cycle valid pulse.
- Used to produce mean-square/energy figures from the squared sample stream.

Parameters:
- WIDTH, 16, width of each incoming squared sample.
- LOG2_COUNT, 4, log2 of samples per frame (frame length N = 2^LOG2_COUNT); legal range 1..8.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- sample_in  input  WIDTH  squared sample; connects to the squarer's `square_out`.
- sample_valid_in  input  1  sample strobe; connects to the squarer's `valid_out`. One sample accepted per high cycle.
- clear_in  input  1  synchronous frame restart; discards the partial frame.
- sum_out  output  WIDTH+LOG2_COUNT  exact sum of the last completed frame.
- mean_out  output  WIDTH  sum_out >> LOG2_COUNT of the last completed frame.
- valid_out  output  1  one-cycle pulse when sum_out/mean_out update.
- count_out  output  LOG2_COUNT  number of samples accepted in the current partial frame.

Behaviour:
- Reset (rst_in high at a rising edge):
  - accumulator, count_out, sum_out, mean_out and valid_out all go to 0.
  - Any partial frame is lost.
  - rst_in has priority over all other inputs.
- Internal accumulator width is WIDTH+LOG2_COUNT, so a full frame of all-ones samples cannot overflow. No saturation or wrap is ever needed.
- Accept rule: a sample is accepted on every cycle with sample_valid_in=1 and clear_in=0. sample_in is sampled only on those cycles; at all other cycles it is don't-care.
- Non-final sample (count_out < N-1):
  - acc <= acc + sample_in
  - count_out <= count_out + 1
- Final sample (count_out == N-1):
  - sum_out <= acc + sample_in
  - mean_out <= (acc + sample_in) >> LOG2_COUNT (truncating)
  - valid_out <= 1 on the next cycle
  - acc <= 0 and count_out <= 0, wrapping naturally from N-1 to 0.
- Latency: valid_out is high in the cycle immediately after the edge that accepted the final sample, i.e. 1 clock after the final strobe.
- valid_out is high for exactly one cycle per completed frame. It is 0 in every other cycle.
- sum_out and mean_out hold their values until the next frame completes or reset occurs. clear_in does not alter them.
- Back-to-back: a sample accepted in the same cycle valid_out is high belongs to the new frame. There are no dead cycles between frames; a continuous strobe every cycle is legal.
- clear_in=1:
  - acc <= 0 and count_out <= 0.
  - Any simultaneous sample_valid_in is discarded.
  - No valid_out is generated.
  - clear_in on the final-sample cycle suppresses that frame's result.
- Counter state: count_out is the only frame-position state. The block has two implicit phases, ACCUM (count 0..N-1) and EMIT (one-cycle valid_out register). EMIT overlaps ACCUM of the next frame.

Optional Feature:
- Macro: SQUARE_ACCUMULATOR_PEAK_EN.
- When defined:
  - Adds output peak_out (WIDTH), the maximum accepted sample of the last completed frame.
  - A running-peak register tracks the maximum within the current frame. It includes the final sample and updates alongside sum_out.
  - The running peak resets to 0 on rst_in, clear_in and frame completion.
  - peak_out resets to 0 and holds between frames.
- When undefined:
  - The port and all peak logic are absent.
  - Remaining behaviour is identical.

Test Plan:
- LOG2_COUNT=2; samples 1, 4, 9, 16 on strobes 3 cycles apart -> one cycle after the 4th strobe, valid_out=1, sum_out=30, mean_out=7; count_out reads 1, 2, 3, 0 after each strobe.
- LOG2_COUNT=2; four samples of 0xFFFF -> sum_out=0x3FFFC, mean_out=0xFFFF, no overflow; peak_out=0xFFFF with PEAK_EN.
- LOG2_COUNT=2; strobe every cycle with 8 samples 1..8 -> valid_out high exactly 2 cycles, 4 cycles apart; sum_out=10 then 26; mean_out=2 then 6.
- Samples 5, 5 then clear_in with a simultaneous strobe of 7, then 2, 2, 2, 2 -> only one valid_out; sum_out=8, mean_out=2; earlier outputs unchanged until then.
- rst_in asserted after 3 of 4 samples (concurrent strobe) -> all outputs 0 next cycle; next 4 samples of 3 give sum_out=12 with no carry-over.
- PEAK_EN, LOG2_COUNT=2; frame 9, 100, 4, 25 then frame 1, 1, 2, 1 -> peak_out=100 after frame 1, then 2 after frame 2.
